// File: rtl/axis_critical_frame_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_critical_frame_gen_if
// Description : 8-bit AXI-Stream bundle used by the critical frame generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_critical_frame_gen_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_critical_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_critical_frame_gen
// Description : Emits one VLAN-tagged critical TSN test frame per start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_critical_frame_gen #(
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [15:0] VLAN_TCI = 16'hE000
) (
    input  wire logic                   axis_aclk,
    input  wire logic                   rst,
    input  wire logic                   start,
    input  wire logic [11:0]            frame_len,
    axis_critical_frame_gen_if.master   m_axis,
    output logic                        busy,
    output logic                        tx_done,
    output logic [31:0]                 frames_sent
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_SEQ  = 2'd2;
    localparam logic [1:0] c_FILL = 2'd3;

    localparam logic [11:0] c_MIN_LEN = 12'd60;
    localparam logic [11:0] c_MAX_LEN = 12'd1518;

    logic [1:0]  r_state;
    logic [11:0] r_idx;
    logic [11:0] r_len;
    logic [31:0] r_seq;
    logic [31:0] r_frames_sent;
    logic        r_tvalid;
    logic [7:0]  r_tdata;
    logic        r_tlast;
    logic        r_busy;
    logic        r_tx_done;

    logic        w_hs;
    logic [11:0] w_len;
    logic [11:0] w_nidx;
    logic [31:0] w_seq;
    logic [7:0]  w_byte;

    assign w_hs   = r_tvalid && m_axis.tready;
    assign w_len  = (frame_len < c_MIN_LEN) ? c_MIN_LEN :
                    (frame_len > c_MAX_LEN) ? c_MAX_LEN : frame_len;
    // Output data is registered one step ahead: the byte for the index about to be presented.
    assign w_nidx = (r_state == c_IDLE) ? 12'd0 : (r_idx + 12'd1);
    assign w_seq  = (r_state == c_IDLE) ? r_frames_sent : r_seq;

    always_comb begin
        w_byte = w_nidx[7:0];
        case (w_nidx)
            12'd0:   w_byte = DST_MAC[47:40];
            12'd1:   w_byte = DST_MAC[39:32];
            12'd2:   w_byte = DST_MAC[31:24];
            12'd3:   w_byte = DST_MAC[23:16];
            12'd4:   w_byte = DST_MAC[15:8];
            12'd5:   w_byte = DST_MAC[7:0];
            12'd6:   w_byte = SRC_MAC[47:40];
            12'd7:   w_byte = SRC_MAC[39:32];
            12'd8:   w_byte = SRC_MAC[31:24];
            12'd9:   w_byte = SRC_MAC[23:16];
            12'd10:  w_byte = SRC_MAC[15:8];
            12'd11:  w_byte = SRC_MAC[7:0];
            12'd12:  w_byte = 8'h81;
            12'd13:  w_byte = 8'h00;
            12'd14:  w_byte = VLAN_TCI[15:8];
            12'd15:  w_byte = VLAN_TCI[7:0];
            12'd16:  w_byte = 8'h66;
            12'd17:  w_byte = 8'hAB;
            12'd18:  w_byte = w_seq[31:24];
            12'd19:  w_byte = w_seq[23:16];
            12'd20:  w_byte = w_seq[15:8];
            12'd21:  w_byte = w_seq[7:0];
            default: w_byte = w_nidx[7:0];
        endcase
    end

    always_ff @(posedge axis_aclk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_idx         <= 12'd0;
            r_len         <= c_MIN_LEN;
            r_seq         <= 32'd0;
            r_frames_sent <= 32'd0;
            r_tvalid      <= 1'b0;
            r_tdata       <= 8'd0;
            r_tlast       <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_done     <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    r_state  <= c_HDR;
                    r_idx    <= 12'd0;
                    r_len    <= w_len;
                    r_seq    <= r_frames_sent;
                    r_tvalid <= 1'b1;
                    r_tdata  <= w_byte;
                    r_tlast  <= 1'b0;
                    r_busy   <= 1'b1;
                end
            end else if (w_hs) begin
                if (r_tlast) begin
                    r_state       <= c_IDLE;
                    r_idx         <= 12'd0;
                    r_tvalid      <= 1'b0;
                    r_tdata       <= 8'd0;
                    r_tlast       <= 1'b0;
                    r_busy        <= 1'b0;
                    r_tx_done     <= 1'b1;
                    r_frames_sent <= r_frames_sent + 32'd1;
                end else begin
                    r_idx   <= w_nidx;
                    r_tdata <= w_byte;
                    r_tlast <= (w_nidx == (r_len - 12'd1));
                    case (r_state)
                        c_HDR:   if (r_idx == 12'd17) r_state <= c_SEQ;
                        c_SEQ:   if (r_idx == 12'd21) r_state <= c_FILL;
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign busy          = r_busy;
    assign tx_done       = r_tx_done;
    assign frames_sent   = r_frames_sent;

endmodule
`default_nettype wire

// File: doc/axis_critical_frame_gen.md
# axis_critical_frame_gen

Transmit-side generator for critical TSN test frames. On a start pulse it emits one complete Ethernet frame as an 8-bit AXI-Stream: an 802.1Q VLAN-tagged header with ethertype 0x66ab, a 32-bit frame sequence number, and a deterministic fill pattern. It sits ahead of the MAC TX path in TSNPerf, and receive-side ethertype classification at the far end must flag every frame it produces as critical. No FCS is generated; the MAC appends it.

## Interface
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, bytes 0-5, MSB first
- SRC_MAC, 48'h00_0A_35_00_00_01, source MAC, bytes 6-11
- VLAN_TCI, 16'hE000, 802.1Q TCI (PCP 7, VID 0), bytes 14-15
- axis_aclk  in  1  clock; everything is synchronous to it
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request one frame; sampled only when busy=0
- frame_len  in  12  frame length in bytes, excluding FCS; sampled with start
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  8  frame byte
- m_axis_tlast  out  1  last byte of frame
- busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse after the last beat is accepted
- frames_sent  out  32  count of completed frames, wraps

## Operation
- Frame layout, by byte index i:
  - 0-5: DST_MAC
  - 6-11: SRC_MAC
  - 12-13: 0x81, 0x00
  - 14-15: VLAN_TCI
  - 16-17: 0x66, 0xab
  - 18-21: seq, big-endian
  - 22 to L-1: i[7:0]
- Effective length L = clamp(frame_len, 60, 1518), computed once at start and held for the whole frame.
- seq is the value of frames_sent when start is accepted. frames_sent increments by 1 on the accepted tlast beat and wraps from 0xFFFF_FFFF to 0.
- State machine:
  - IDLE -> HDR on start while busy=0.
  - HDR covers bytes 0-17, then -> SEQ.
  - SEQ covers bytes 18-21, then -> FILL.
  - FILL covers bytes 22 to L-1, then -> IDLE on the accepted beat with tlast.
- A 12-bit byte index advances only on a handshake (m_axis_tvalid && m_axis_tready). All data is selected from the byte index, so no per-byte shift registers are needed.
- start is ignored whenever busy=1, including the cycle of the final handshake. No queuing.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, tx_done=0, frames_sent=0, state IDLE, byte index 0.

## Timing
- start accepted at cycle N: busy=1 and m_axis_tvalid=1 with byte 0 from N+1. Outputs are registered.
- m_axis_tvalid stays high from the first to the last beat of a frame; the generator never inserts bubbles.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- m_axis_tlast=1 exactly on byte L-1.
- Final handshake at cycle M:
  - At M+1: m_axis_tvalid=0, m_axis_tlast=0, busy=0, tx_done=1 for one cycle, frames_sent updated.
  - The earliest next start is accepted at M+1, with its first beat at M+2.
- With m_axis_tready held at 1, a frame occupies exactly L+1 cycles from start to tx_done. Minimum inter-frame spacing is one idle cycle.
- Asserting rst mid-frame immediately forces every output to its reset value. The partial frame is abandoned without tlast, and frames_sent is cleared.

## Test plan
- Reset, then start with frame_len=60 and m_axis_tready=1 -> expect:
  - 60 beats on cycles 1-60 after start, tlast only on beat 59
  - bytes 12-17 = 81 00 E0 00 66 ab
  - bytes 18-21 = 00 00 00 00, byte 22 = 0x16, byte 59 = 0x3b
  - tx_done on cycle 61, frames_sent=1
- Clamping:
  - frame_len=20 -> 60 beats.
  - frame_len=2000 -> 1518 beats, last byte 0xed (1517 mod 256).
  - frame_len=1000 -> 1000 beats.
- Random m_axis_tready at 50% duty over 3 frames -> byte stream identical to the no-stall case, tdata and tlast stable during every stall, seq bytes 0, 1, 2.
- start held high continuously -> back-to-back frames with exactly one idle cycle between frames; start pulses during busy create no extra frames.
- Force frames_sent to 0xFFFF_FFFF, send two frames -> seq bytes FF FF FF FF then 00 00 00 00, frames_sent ends at 1.
- Assert rst at beat 30 of a frame -> m_axis_tvalid drops in the same cycle with no tlast, frames_sent=0. The next start produces a full frame with seq 0. Loop the stream into the receive-side ethertype checker -> is_critical_frame=1 after byte 18 of every frame.
